// File: rtl/dm_sram_ctrl.sv
// dm_sram_ctrl: data-memory access controller between the CPU MEM-stage DM port
// and a single-port, word-write-only SRAM macro with RD_LAT-cycle read latency.
// Full-word stores go straight through with no stall. Byte and halfword stores
// are done as a read-modify-write. Loads stall the pipeline until sram_q is
// valid, then return the data on req_do.
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-low reset
//   req_oe               load request
//   req_web[3:0]         active-low byte write enables (4'hF = no write)
//   req_addr, req_di     word address, store data (byte-lane aligned)
//   req_do, rdata_valid  load data and its one-cycle update pulse (registered)
//   stall                pipeline hold while an access is in flight
//   sram_ceb, sram_web   SRAM chip/write enables, active-low
//   sram_a, sram_d       SRAM address and write data
//   sram_q               SRAM read data, valid RD_LAT cycles after a read issue
module dm_sram_ctrl #(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned DATA_W = 32,   // must be 32: four byte lanes
    parameter int unsigned RD_LAT = 2     // legal 1..4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_oe,
    input  logic [3:0]        req_web,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_di,
    output logic [DATA_W-1:0] req_do,
    output logic              rdata_valid,
    output logic              stall,
    output logic              sram_ceb,
    output logic              sram_web,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_d,
    input  logic [DATA_W-1:0] sram_q
);

    localparam int unsigned CNT_W   = 2;
    localparam int unsigned N_BYTES = 4;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RD_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RD_WAIT  = 2'd1,
        S_RMW_WAIT = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] req_do_q, req_do_d;
    logic              rdata_valid_q, rdata_valid_d;

    logic              stall_c;
    logic              ceb_c;
    logic              web_c;
    logic [ADDR_W-1:0] a_c;
    logic [DATA_W-1:0] d_c;

    logic is_wrf;
    logic is_wr;
    logic is_rd;

    // Request classification; any write enable overrides req_oe.
    assign is_wrf = (req_web == 4'h0);
    assign is_wr  = (req_web != 4'hF);
    assign is_rd  = req_oe & ~is_wr;

    // State, wait counter and load-return registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            req_do_q      <= '0;
            rdata_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            req_do_q      <= req_do_d;
            rdata_valid_q <= rdata_valid_d;
        end
    end

    // Next-state and SRAM command decode.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        req_do_d      = req_do_q;
        rdata_valid_d = 1'b0;
        stall_c       = 1'b0;
        ceb_c         = 1'b1;
        web_c         = 1'b1;
        a_c           = '0;
        d_c           = '0;

        unique case (state_q)
            S_IDLE: begin
                if (is_wrf) begin
                    ceb_c = 1'b0;
                    web_c = 1'b0;
                    a_c   = req_addr;
                    d_c   = req_di;
                end else if (is_wr || is_rd) begin
                    // Loads and partial stores both begin with an SRAM read.
                    ceb_c   = 1'b0;
                    a_c     = req_addr;
                    stall_c = 1'b1;
                    cnt_d   = CNT_INIT;
                    state_d = is_wr ? S_RMW_WAIT : S_RD_WAIT;
                end
            end

            S_RD_WAIT: begin
                if (cnt_q != '0) begin
                    stall_c = 1'b1;
                    cnt_d   = cnt_q - CNT_W'(1);
                end else begin
                    req_do_d      = sram_q;
                    rdata_valid_d = 1'b1;
                    state_d       = S_IDLE;
                end
            end

            S_RMW_WAIT: begin
                if (cnt_q != '0) begin
                    stall_c = 1'b1;
                    cnt_d   = cnt_q - CNT_W'(1);
                end else begin
                    ceb_c = 1'b0;
                    web_c = 1'b0;
                    a_c   = req_addr;
                    // Enabled lanes take store data, the rest keep the old word.
                    for (int unsigned i = 0; i < N_BYTES; i++) begin
                        d_c[8*i +: 8] = req_web[i] ? sram_q[8*i +: 8] : req_di[8*i +: 8];
                    end
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // While reset is held, nothing reaches the SRAM and the pipeline is released.
    assign stall       = rst & stall_c;
    assign sram_ceb    = ~rst | ceb_c;
    assign sram_web    = ~rst | web_c;
    assign sram_a      = rst ? a_c : '0;
    assign sram_d      = rst ? d_c : '0;
    assign req_do      = req_do_q;
    assign rdata_valid = rdata_valid_q;

endmodule

// File: doc/dm_sram_ctrl.md
Name: dm_sram_ctrl

Overview:
- Data-memory access controller sitting directly downstream of the CPU's MEM-stage data-memory port.
- Accepts the CPU's DM request (output-enable, per-byte active-low write enables, word address, write data) and drives a single-port, word-write-only SRAM macro with configurable read latency.
- Partial (byte/halfword) stores are performed as read-modify-write.
- Asserts a stall back to the pipeline while an access is in flight, and returns load data.

Parameters:
- ADDR_W, 14, word-address width (matches the CPU DM address).
- DATA_W, 32, data width; must be 32 (four byte lanes).
- RD_LAT, 2, SRAM read latency in cycles from issue to valid sram_q; legal 1..4.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_oe  in  1  read request (load).
- req_web  in  4  active-low byte write enables; bit i covers bits 8i+7:8i; 4'hF = no write.
- req_addr  in  ADDR_W  word address.
- req_di  in  32  store data, byte-aligned to lanes.
- req_do  out  32  load data.
- rdata_valid  out  1  one-cycle pulse when req_do is updated.
- stall  out  1  pipeline hold; CPU keeps all req_* stable while 1.
- sram_ceb  out  1  SRAM chip enable, active-low.
- sram_web  out  1  SRAM write enable, active-low, full word only.
- sram_a  out  ADDR_W  SRAM address.
- sram_d  out  32  SRAM write data.
- sram_q  in  32  SRAM read data, valid RD_LAT cycles after a read issue.

Behaviour:
- Reset (rst=0, asynchronous) sets:
  - state=IDLE, cnt=0.
  - req_do=32'h0, rdata_valid=0.
  - stall=0, sram_ceb=1, sram_web=1, sram_a=0, sram_d=0.
- Request classification in IDLE:
  - WRF (full write): req_web==4'h0.
  - WRP (partial write): req_web neither 4'h0 nor 4'hF.
  - RD (read): req_oe=1 and req_web==4'hF.
  - None: req_oe=0 and req_web==4'hF.
  - A write takes precedence when req_oe=1 together with any write enable; the access is treated as a write and no read data is returned.
- States: IDLE, RD_WAIT, RMW_WAIT.
- IDLE, no request: sram_ceb=1, stall=0.
- IDLE, WRF: in the same cycle, combinationally drive sram_ceb=0, sram_web=0, sram_a=req_addr, sram_d=req_di, stall=0. Zero stall cycles; stay in IDLE.
- IDLE, RD: in the same cycle, drive sram_ceb=0, sram_web=1, sram_a=req_addr, stall=1. Load cnt=RD_LAT-1 and go to RD_WAIT.
- IDLE, WRP: same SRAM read issue and stall=1. Load cnt=RD_LAT-1 and go to RMW_WAIT.
- RD_WAIT:
  - sram_ceb=1.
  - While cnt!=0: stall=1, cnt decrements.
  - When cnt==0: sram_q is valid; stall=0; req_do<=sram_q at the clock edge; rdata_valid=1 in the following cycle; return to IDLE.
- RMW_WAIT:
  - While cnt!=0: stall=1, sram_ceb=1, cnt decrements.
  - When cnt==0: drive sram_ceb=0, sram_web=0, sram_a=req_addr, stall=0.
  - Merge: sram_d byte i = req_web[i]==0 ? req_di byte i : sram_q byte i.
  - Return to IDLE.
- Stall cycles per access: WRF 0; RD and WRP each RD_LAT. Completion is always the cycle in which stall=0.
- Back-to-back: a new request presented in the cycle after completion is accepted in IDLE with no bubble.
- rdata_valid:
  - Registered, high exactly one cycle per completed RD.
  - Never asserted for writes.
- req_do holds its last load value until the next RD completes.
- Reset mid-access: the FSM aborts to IDLE immediately, stall drops to 0, sram_ceb=1, and no SRAM write is issued for an aborted RMW.
- sram_a and sram_d are don't-care whenever sram_ceb=1 but must be driven without X (hold 0 or the last value).
- RD_LAT=1: cnt is loaded with 0, so RD_WAIT/RMW_WAIT completes on the first cycle after issue.

Test Plan (RD_LAT=2):
1. Reset then idle: rst low mid-run -> stall=0, sram_ceb=1, req_do=0, rdata_valid=0 immediately and held.
2. WRF: req_web=4'h0, addr=14'h010, di=32'hDEADBEEF -> same cycle sram_ceb=0, sram_web=0, sram_a=14'h010, sram_d=DEADBEEF, stall=0.
3. RD after (2): req_oe=1, addr=14'h010 -> stall=1 for 2 cycles, req_do=32'hDEADBEEF, rdata_valid pulses once in the cycle after stall falls.
4. WRP: req_web=4'b1100, di=32'h00001234, addr=14'h010 -> 2 stall cycles, then SRAM write of 32'hDEAD1234; a subsequent read returns DEAD1234.
5. Simultaneous oe with web=4'h0 -> treated as WRF, zero stall, no rdata_valid pulse.
6. Reset asserted in the second RMW_WAIT cycle -> no write issued (sram_web stays 1); a subsequent read of that address returns the pre-RMW value.
